voice_slot_scheduler: RTL and testbench
=======================================

// Module: voice_slot_scheduler
// PURPOSE
//  Allocates note requests onto NUM_SLOTS time-multiplexed voice slots of the shared
//  tone/sample engine. Rotates one slot per clk and presents that slot's divider,
//  matching the engine's one-voice-per-cycle sharing. Upstream: song sequencers and
//  host note requesters. Downstream: the divider input of the sample engine.
//  On note_on with every slot busy, steals the least-recently-allocated slot.
// PARAMETERS
//  NUM_SLOTS  4   voice slots; power of 2; slot index width SW = log2(NUM_SLOTS)
//  DIV_W      12  divider width; divider 0 = silence
//  TAG_W      4   requester note tag width; note_off matches on tag
// PORTS
//  clk          in   1      clock
//  rst_n        in   1      reset, synchronous, active-low
//  req_valid    in   1      request present
//  req_ready    out  1      scheduler can accept
//  req_note_on  in   1      1 = note_on, 0 = note_off
//  req_tag      in   TAG_W  note tag
//  req_div      in   DIV_W  divider for note_on (ignored for note_off)
//  mute         in   1      forces slot_div = 0; table keeps state
//  slot_idx     out  SW     slot presented this cycle
//  slot_div     out  DIV_W  divider of slot_idx (0 if inactive or muted)
//  slot_active  out  1      slot_idx holds a note
//  stole        out  1      1-cycle pulse: note_on evicted a note
//  off_miss     out  1      1-cycle pulse: note_off tag matched no slot
// BEHAVIOUR
//  Reset: all entries inactive, ranks 0, rotor 0, FSM IDLE. slot_idx=0, slot_div=0,
//   slot_active=0, stole=0, off_miss=0, req_ready=1 in the first cycle after reset.
//   Reset mid-request drops the request; no table change.
//  Entry per slot: active, tag, div, rank[SW-1:0] (LRU order; higher = newer).
//  Rotor: free-running SW-bit counter, +1 per clk, wraps NUM_SLOTS-1 -> 0.
//   slot_idx/slot_div/slot_active are registered from rotor and table: 1-cycle latency.
//  FSM: IDLE (req_ready=1) -> on req_valid&&req_ready, capture request -> COMMIT
//   (req_ready=0) -> update table -> IDLE. Max one request per 2 cycles.
//   Inputs are sampled only on the accept edge; later changes are ignored.
//  note_on target, in priority order:
//   1) active slot with tag == req_tag: retrigger; div updated.
//   2) lowest-index inactive slot.
//   3) active slot with rank 0: steal it; stole=1 the cycle after COMMIT.
//  Rank update for target s: active slots with rank > old rank[s] decrement (only
//   if s was active). s gets rank = (active count after update) - 1.
//  note_off: matching active slot -> inactive; slots ranked above it decrement.
//   No match -> no change; off_miss=1 the cycle after COMMIT.
//  Duplicate tags never coexist: rule 1 prevents them.
//  COMMIT write and rotor read of the same slot in one cycle: the output shows the
//   old entry; the new value appears at the next visit (≤ NUM_SLOTS cycles).
//  mute: combinational mask on the registered slot_div. slot_active is unaffected.
//  Widths: rank arithmetic is modulo 2^SW and never underflows, because decrement
//   applies only to ranks above another rank.
// STRUCTURE
//  music_pkg: NUM_SLOTS/DIV_W/TAG_W defaults, slot_entry_t {active, tag, div, rank},
//   req_t {note_on, tag, div}, fsm_state_t {IDLE, COMMIT}.
//  Sub-module slot_alloc (combinational): tag match, first free, rank-0 victim ->
//   target index plus hit/free/steal flags. The table, FSM and rotor live in the top.
// TESTING
//  1 Reset, idle 8 cycles -> slot_idx 0,1,2,3,0..; slot_div=0; slot_active=0; req_ready=1.
//  2 note_on tag1 div956 -> slot0 active; slot_div=956 on the next slot_idx==0 cycle.
//    req_ready=0 for exactly 1 cycle.
//  3 note_on tags1..4 (divs 956,1277,1137,1519), then note_on tag5 div1433 ->
//    stole pulse; slot0 (tag1) now div1433; ranks slot1..3=0,1,2, slot0=3.
//  4 note_on tag2 div1914 while tag2 is active in slot1 -> no steal; slot1 div 1914;
//    slot1 becomes newest.
//  5 note_off tag9 (absent) -> off_miss pulse, table unchanged.
//    note_off tag3 -> slot2 inactive, slot_div=0 at slot_idx==2.
//  6 mute=1 with 4 active -> slot_div=0 at every slot, slot_active=1; release mute
//    -> dividers restored. Assert rst_n=0 during COMMIT -> request dropped, table empty.

Source files
------------

// File: rtl/music_pkg.sv
// Shared parameters and types for the voice slot scheduler.
//   NUM_SLOTS : number of time-multiplexed voice slots (power of 2)
//   DIV_W     : tone divider width (0 = silence)
//   TAG_W     : requester note tag width
//   SW        : slot index / rank width
package music_pkg;

  localparam int unsigned NUM_SLOTS = 4;
  localparam int unsigned DIV_W     = 12;
  localparam int unsigned TAG_W     = 4;
  localparam int unsigned SW        = $clog2(NUM_SLOTS);

  // One voice slot; rank orders allocations (higher = newer)
  typedef struct packed {
    logic             active;
    logic [TAG_W-1:0] tag;
    logic [DIV_W-1:0] div;
    logic [SW-1:0]    rank;
  } slot_entry_t;

  // Captured note request
  typedef struct packed {
    logic             note_on;
    logic [TAG_W-1:0] tag;
    logic [DIV_W-1:0] div;
  } req_t;

  typedef enum logic {
    IDLE   = 1'b0,
    COMMIT = 1'b1
  } fsm_state_t;

endpackage

// File: rtl/slot_alloc.sv
// Combinational target selection for a note request.
//   active/tags/ranks : per-slot table fields
//   tag               : request tag
//   target            : chosen slot (tag hit > lowest free > rank-0 victim)
//   hit/free/steal    : which rule produced target
module slot_alloc
  import music_pkg::*;
(
  input  logic [NUM_SLOTS-1:0] active,
  input  logic [TAG_W-1:0]     tags [NUM_SLOTS],
  input  logic [SW-1:0]        ranks [NUM_SLOTS],
  input  logic [TAG_W-1:0]     tag,
  output logic [SW-1:0]        target,
  output logic                 hit,
  output logic                 free,
  output logic                 steal
);

  logic [SW-1:0] hit_idx;
  logic [SW-1:0] free_idx;
  logic [SW-1:0] victim_idx;
  logic          victim_found;

  // Descending scan so the lowest matching index wins
  always_comb begin
    hit          = 1'b0;
    free         = 1'b0;
    victim_found = 1'b0;
    hit_idx      = '0;
    free_idx     = '0;
    victim_idx   = '0;
    for (int i = int'(NUM_SLOTS) - 1; i >= 0; i--) begin
      if (active[i] && (tags[i] == tag)) begin
        hit     = 1'b1;
        hit_idx = SW'(i);
      end
      if (!active[i]) begin
        free     = 1'b1;
        free_idx = SW'(i);
      end
      if (active[i] && (ranks[i] == '0)) begin
        victim_found = 1'b1;
        victim_idx   = SW'(i);
      end
    end
  end

  always_comb begin
    steal  = !hit && !free && victim_found;
    target = hit ? hit_idx : (free ? free_idx : victim_idx);
  end

endmodule

// File: rtl/voice_slot_scheduler.sv
// Allocates note requests onto time-multiplexed voice slots and presents one
// slot's divider per clock to the shared tone engine.
//   clk, rst_n       : clock, synchronous active-low reset
//   req_*            : note request handshake (note_on/off, tag, divider)
//   mute             : masks slot_div to 0 without touching the table
//   slot_idx/div/act : slot presented this cycle (registered from rotor)
//   stole/off_miss   : 1-cycle event pulses after a request commits
module voice_slot_scheduler
  import music_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_note_on,
  input  logic [TAG_W-1:0] req_tag,
  input  logic [DIV_W-1:0] req_div,
  input  logic             mute,
  output logic [SW-1:0]    slot_idx,
  output logic [DIV_W-1:0] slot_div,
  output logic             slot_active,
  output logic             stole,
  output logic             off_miss
);

  localparam int unsigned CW = SW + 1;

  slot_entry_t      entries     [NUM_SLOTS];
  slot_entry_t      entries_nxt [NUM_SLOTS];
  fsm_state_t       state;
  req_t             req_q;
  logic [SW-1:0]    rotor;
  logic [DIV_W-1:0] slot_div_q;

  logic [NUM_SLOTS-1:0] act_vec;
  logic [TAG_W-1:0]     tag_vec  [NUM_SLOTS];
  logic [SW-1:0]        rank_vec [NUM_SLOTS];
  logic [SW-1:0]        target;
  logic                 hit;
  logic                 free;
  logic                 steal;
  logic [CW-1:0]        active_cnt;
  logic [SW-1:0]        old_rank;
  logic                 was_active;

  always_comb begin
    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
      act_vec[i]  = entries[i].active;
      tag_vec[i]  = entries[i].tag;
      rank_vec[i] = entries[i].rank;
    end
  end

  slot_alloc u_alloc (
    .active (act_vec),
    .tags   (tag_vec),
    .ranks  (rank_vec),
    .tag    (req_q.tag),
    .target (target),
    .hit    (hit),
    .free   (free),
    .steal  (steal)
  );

  // Next table for the captured request; slots above the target's old rank close the gap
  always_comb begin
    entries_nxt = entries;
    active_cnt  = '0;
    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
      active_cnt = active_cnt + CW'(entries[i].active);
    end
    old_rank   = entries[target].rank;
    was_active = entries[target].active;
    if (req_q.note_on) begin
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
        if (was_active && entries[i].active && (SW'(i) != target) &&
            (entries[i].rank > old_rank)) begin
          entries_nxt[i].rank = entries[i].rank - SW'(1);
        end
      end
      entries_nxt[target].active = 1'b1;
      entries_nxt[target].tag    = req_q.tag;
      entries_nxt[target].div    = req_q.div;
      // Newest rank = active count after update minus one
      entries_nxt[target].rank   = was_active ? SW'(active_cnt - CW'(1)) : SW'(active_cnt);
    end else if (hit) begin
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
        if (entries[i].active && (SW'(i) != target) && (entries[i].rank > old_rank)) begin
          entries_nxt[i].rank = entries[i].rank - SW'(1);
        end
      end
      entries_nxt[target] = '0;
    end
  end

  // Table, request FSM, rotor and registered slot outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
        entries[i] <= '0;
      end
      state       <= IDLE;
      req_q       <= '0;
      rotor       <= '0;
      slot_idx    <= '0;
      slot_div_q  <= '0;
      slot_active <= 1'b0;
      stole       <= 1'b0;
      off_miss    <= 1'b0;
      req_ready   <= 1'b1;
    end else begin
      rotor       <= rotor + SW'(1);
      slot_idx    <= rotor;
      // Reads the pre-commit entry when a commit hits the same slot
      slot_div_q  <= entries[rotor].active ? entries[rotor].div : '0;
      slot_active <= entries[rotor].active;
      stole       <= 1'b0;
      off_miss    <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_q.note_on <= req_note_on;
            req_q.tag     <= req_tag;
            req_q.div     <= req_div;
            state         <= COMMIT;
            req_ready     <= 1'b0;
          end
        end
        COMMIT: begin
          entries   <= entries_nxt;
          stole     <= req_q.note_on && steal;
          off_miss  <= !req_q.note_on && !hit;
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign slot_div = mute ? '0 : slot_div_q;

endmodule

// File: tb/tb_voice_slot_scheduler.sv
// Directed bench for voice_slot_scheduler: table-driven request vectors plus
// hand sequences for reset, mute and reset during commit.
module tb_voice_slot_scheduler;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_note_on;
  logic [3:0]  req_tag;
  logic [11:0] req_div;
  logic        mute;
  logic [1:0]  slot_idx;
  logic [11:0] slot_div;
  logic        slot_active;
  logic        stole;
  logic        off_miss;

  voice_slot_scheduler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_note_on (req_note_on),
    .req_tag     (req_tag),
    .req_div     (req_div),
    .mute        (mute),
    .slot_idx    (slot_idx),
    .slot_div    (slot_div),
    .slot_active (slot_active),
    .stole       (stole),
    .off_miss    (off_miss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        note_on;
    logic [3:0]  tag;
    logic [11:0] div;
    logic        exp_stole;
    logic        exp_miss;
    logic [1:0]  exp_slot;
    logic [11:0] exp_div;
    logic        exp_active;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  int tests;
  int errors;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issue one request, check handshake and pulses, then inspect the target slot
  task automatic apply_req(input int n, input vec_t v);
    int  w;
    bit  found;
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk($sformatf("v%0d ready_wait", n), int'(req_ready), 1);
    req_valid   = 1'b1;
    req_note_on = v.note_on;
    req_tag     = v.tag;
    req_div     = v.div;
    @(negedge clk);
    chk($sformatf("v%0d ready_low", n), int'(req_ready), 0);
    req_valid   = 1'b0;
    req_note_on = 1'($urandom);
    req_tag     = 4'($urandom);
    req_div     = 12'($urandom);
    @(negedge clk);
    chk($sformatf("v%0d stole", n), int'(stole), int'(v.exp_stole));
    chk($sformatf("v%0d off_miss", n), int'(off_miss), int'(v.exp_miss));
    chk($sformatf("v%0d ready_back", n), int'(req_ready), 1);
    @(negedge clk);
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (slot_idx == v.exp_slot) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk($sformatf("v%0d slot_seen", n), int'(found), 1);
    chk($sformatf("v%0d slot_div", n), int'(slot_div), int'(v.exp_div));
    chk($sformatf("v%0d slot_active", n), int'(slot_active), int'(v.exp_active));
  endtask

  initial begin
    logic [11:0] mdiv [4];
    tests = 0;
    errors = 0;

    //          on    tag    div       stole miss  slot  exp_div    act
    vecs[0]  = '{1'b1, 4'd1, 12'd956,  1'b0, 1'b0, 2'd0, 12'd956,  1'b1};
    vecs[1]  = '{1'b1, 4'd2, 12'd1277, 1'b0, 1'b0, 2'd1, 12'd1277, 1'b1};
    vecs[2]  = '{1'b1, 4'd3, 12'd1137, 1'b0, 1'b0, 2'd2, 12'd1137, 1'b1};
    vecs[3]  = '{1'b1, 4'd4, 12'd1519, 1'b0, 1'b0, 2'd3, 12'd1519, 1'b1};
    vecs[4]  = '{1'b1, 4'd5, 12'd1433, 1'b1, 1'b0, 2'd0, 12'd1433, 1'b1};
    vecs[5]  = '{1'b1, 4'd2, 12'd1914, 1'b0, 1'b0, 2'd1, 12'd1914, 1'b1};
    vecs[6]  = '{1'b0, 4'd9, 12'd0,    1'b0, 1'b1, 2'd0, 12'd1433, 1'b1};
    vecs[7]  = '{1'b0, 4'd3, 12'd0,    1'b0, 1'b0, 2'd2, 12'd0,    1'b0};
    vecs[8]  = '{1'b1, 4'd6, 12'd1000, 1'b0, 1'b0, 2'd2, 12'd1000, 1'b1};
    vecs[9]  = '{1'b1, 4'd7, 12'd1100, 1'b1, 1'b0, 2'd3, 12'd1100, 1'b1};
    vecs[10] = '{1'b1, 4'd8, 12'd1200, 1'b1, 1'b0, 2'd0, 12'd1200, 1'b1};
    vecs[11] = '{1'b0, 4'd4, 12'd0,    1'b0, 1'b1, 2'd3, 12'd1100, 1'b1};

    mdiv[0] = 12'd1200;
    mdiv[1] = 12'd1914;
    mdiv[2] = 12'd1000;
    mdiv[3] = 12'd1100;

    rst_n       = 1'b0;
    req_valid   = 1'b0;
    req_note_on = 1'b0;
    req_tag     = '0;
    req_div     = '0;
    mute        = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst req_ready", int'(req_ready), 1);
    chk("rst slot_idx", int'(slot_idx), 0);
    chk("rst slot_div", int'(slot_div), 0);
    chk("rst slot_active", int'(slot_active), 0);
    chk("rst stole", int'(stole), 0);
    chk("rst off_miss", int'(off_miss), 0);
    rst_n = 1'b1;

    // Idle rotation after reset
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("idle%0d slot_idx", k), int'(slot_idx), k % 4);
      chk($sformatf("idle%0d slot_div", k), int'(slot_div), 0);
      chk($sformatf("idle%0d slot_active", k), int'(slot_active), 0);
      chk($sformatf("idle%0d req_ready", k), int'(req_ready), 1);
    end

    for (int n = 0; n < NV; n++) begin
      apply_req(n, vecs[n]);
    end

    // Mute masks dividers only
    mute = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("mute%0d slot_div", k), int'(slot_div), 0);
      chk($sformatf("mute%0d slot_active", k), int'(slot_active), 1);
    end
    mute = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("unmute%0d slot_div", k), int'(slot_div), int'(mdiv[slot_idx]));
    end

    // Reset landing on the commit edge drops the request and clears the table
    req_valid   = 1'b1;
    req_note_on = 1'b1;
    req_tag     = 4'd9;
    req_div     = 12'd500;
    @(negedge clk);
    chk("rstc ready_low", int'(req_ready), 0);
    req_valid = 1'b0;
    rst_n     = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("rstc%0d slot_active", k), int'(slot_active), 0);
      chk($sformatf("rstc%0d slot_div", k), int'(slot_div), 0);
      chk($sformatf("rstc%0d stole", k), int'(stole), 0);
      chk($sformatf("rstc%0d req_ready", k), int'(req_ready), 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
